// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main controller for a multicycle MIPS-subset datapath. It steps each
// instruction through fetch, decode, execute, memory and writeback states. It
// drives the datapath mux selects and write enables, and it issues the 4-bit
// ALU control word.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   opcode       IR[31:26]; sampled in DECODE
//   funct        IR[5:0]; sampled in EXEC
//   zero         ALU zero flag, used by BRANCH
//   mem_ready    memory finishes the current read/write this cycle
//   alu_control  {Ainvert, Bnegate/Cin, op[1:0]}
//   alu_src_a    0=PC, 1=reg A
//   alu_src_b    00=reg B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   pc_source    00=ALU result, 01=ALUOut, 10=jump target
//   pc_en        PC write enable
//   iord         0=PC address, 1=ALUOut address
//   mem_read     memory read request
//   mem_write    memory write request
//   ir_write     IR load
//   reg_dst      0=rt, 1=rd
//   mem_to_reg   0=ALUOut, 1=MDR
//   reg_write    register file write
//   illegal      one-cycle pulse on an unsupported opcode or funct
//   mem_timeout  sticky memory-wait timeout flag; cleared only by reset
//   state        current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15  // legal range 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  // lw/sw direction is captured in DECODE, so MEMADR does not look at opcode again.
  logic       is_store_q, is_store_d;

  logic       wait_state;
  logic       expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      is_store_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      is_store_q    <= is_store_d;
    end
  end

  // The three memory-handshake states share one wait counter.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign expired    = wait_state && (wait_cnt_q == TIMEOUT_C) && !mem_ready;

  always_comb begin
    state_d       = S_FETCH;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    is_store_d    = is_store_q;

    alu_control = ALU_ADD;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;  // timeout also lands here, with the counter restarted
        end
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        is_store_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    state_d = S_MEMWB;
        else if (expired) state_d = S_FETCH;
        else              state_d = S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready || expired) state_d = S_FETCH;
        else                      state_d = S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        state_d   = S_RWB;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b100111: alu_control = ALU_NOR;
          6'b101010: alu_control = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = 2'b01;
        pc_en       = zero;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;  // unused encodings recover with default outputs
    endcase

    if (wait_state && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
      if (expired) mem_timeout_d = 1'b1;
    end
    // Restart the count on every entry to a wait state. A FETCH timeout re-enters FETCH.
    if ((state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR) &&
        (state_d != state_q || expired)) begin
      wait_cnt_d = 8'd0;
    end

    // Reset is asynchronous, so the enables must be suppressed combinationally too.
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal, mem_timeout;
  logic [3:0] state;

  multicycle_control #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  // One expected cycle: inputs to apply plus the outputs they must produce.
  typedef struct packed {
    logic       last;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       ready;
    logic [3:0] st;
    logic [3:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, ill, mto;
  } cyc_t;

  cyc_t q[$];
  int   st_log[$];
  bit   sticky_to = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {legal, alu code} for an R-type funct.
  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return {1'b1, 4'b0001};
      6'b100010: return {1'b1, 4'b0101};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0010};
      6'b100111: return {1'b1, 4'b1100};
      6'b101010: return {1'b1, 4'b0111};
      default:   return {1'b0, 4'b0001};
    endcase
  endfunction

  // Expected outputs of a control step, written straight from the per-state table.
  function automatic cyc_t mk(input int st, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic rdy);
    cyc_t c;
    logic [4:0] r;
    c = '0;
    c.op = op; c.fn = fn; c.zero = z; c.ready = rdy;
    c.st = 4'(st); c.alu = 4'b0001; c.mto = sticky_to;
    case (st)
      0:  begin c.mrd = 1; c.sb = 2'b01; c.irw = rdy; c.pc_en = rdy; end
      1:  c.sb = 2'b11;
      2:  begin c.sa = 1; c.sb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.m2r = 1; c.rw = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin r = r_alu(fn); c.sa = 1; c.alu = r[3:0]; c.ill = ~r[4]; end
      7:  begin c.rdst = 1; c.rw = 1; end
      8:  begin c.sa = 1; c.alu = 4'b0101; c.ps = 2'b01; c.pc_en = z; end
      9:  begin c.sa = 1; c.sb = 2'b10; end
      10: c.rw = 1;
      11: begin c.ps = 2'b10; c.pc_en = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic gen_fetch(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fwait);
    for (int i = 0; i < fwait; i++) q.push_back(mk(0, op, fn, z, 1'b0));
    q.push_back(mk(0, op, fn, z, 1'b1));
  endtask

  // A memory state that sees mwait low cycles: more than TMO low cycles means the
  // (TMO+1)th low cycle expires and the flag shows from the next cycle on.
  task automatic gen_mem(input int st, input logic [5:0] op, input logic [5:0] fn,
                         input int mwait, output bit to);
    if (mwait > TMO) begin
      for (int i = 0; i <= TMO; i++) q.push_back(mk(st, op, fn, 1'b0, 1'b0));
      sticky_to = 1'b1;
      to = 1'b1;
    end else begin
      for (int i = 0; i < mwait; i++) q.push_back(mk(st, op, fn, 1'b0, 1'b0));
      q.push_back(mk(st, op, fn, 1'b0, 1'b1));
      to = 1'b0;
    end
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fwait, input int mwait);
    cyc_t c;
    bit   to;
    gen_fetch(op, fn, z, fwait);
    c = mk(1, op, fn, z, 1'b1);
    case (op)
      LW: begin
        q.push_back(c); q.push_back(mk(2, op, fn, z, 1'b1));
        gen_mem(3, op, fn, mwait, to);
        if (!to) q.push_back(mk(4, op, fn, z, 1'b1));
      end
      SW: begin
        q.push_back(c); q.push_back(mk(2, op, fn, z, 1'b1));
        gen_mem(5, op, fn, mwait, to);
      end
      RT: begin
        q.push_back(c);
        c = mk(6, op, fn, z, 1'b1);
        q.push_back(c);
        if (!c.ill) q.push_back(mk(7, op, fn, z, 1'b1));
      end
      BEQ:  begin q.push_back(c); q.push_back(mk(8, op, fn, z, 1'b1)); end
      ADDI: begin q.push_back(c); q.push_back(mk(9, op, fn, z, 1'b1)); q.push_back(mk(10, op, fn, z, 1'b1)); end
      JMP:  begin q.push_back(c); q.push_back(mk(11, op, fn, z, 1'b1)); end
      default: begin c.ill = 1'b1; q.push_back(c); end
    endcase
    c = q.pop_back();
    c.last = 1'b1;
    q.push_back(c);
  endtask

  // Entered and left at posedge+1: drive, compare at negedge, advance.
  task automatic run_q();
    cyc_t e;
    int   n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      opcode = e.op; funct = e.fn; zero = e.zero; mem_ready = e.ready;
      @(negedge clk);
      chk("state", 8'(state), 8'(e.st));
      chk("alu_control", 8'(alu_control), 8'(e.alu));
      chk("alu_src_a", 8'(alu_src_a), 8'(e.sa));
      chk("alu_src_b", 8'(alu_src_b), 8'(e.sb));
      chk("pc_source", 8'(pc_source), 8'(e.ps));
      chk("pc_en", 8'(pc_en), 8'(e.pc_en));
      chk("iord", 8'(iord), 8'(e.iord));
      chk("mem_read", 8'(mem_read), 8'(e.mrd));
      chk("mem_write", 8'(mem_write), 8'(e.mwr));
      chk("ir_write", 8'(ir_write), 8'(e.irw));
      chk("reg_dst", 8'(reg_dst), 8'(e.rdst));
      chk("mem_to_reg", 8'(mem_to_reg), 8'(e.m2r));
      chk("reg_write", 8'(reg_write), 8'(e.rw));
      chk("illegal", 8'(illegal), 8'(e.ill));
      chk("mem_timeout", 8'(mem_timeout), 8'(e.mto));
      st_log.push_back(int'(state));
      n++;
      if (e.last) begin
        $display("txn op=%b fn=%b zero=%0d cycles=%0d errors=%0d", e.op, e.fn, e.zero, n, errors);
        n = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lw_seq[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};

    // Reset held: state FETCH, enables forced low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_mem_read", 8'(mem_read), 8'd0);
    chk("rst_ir_write", 8'(ir_write), 8'd0);
    chk("rst_pc_en", 8'(pc_en), 8'd0);
    chk("rst_mem_timeout", 8'(mem_timeout), 8'd0);
    reset = 1'b0;

    // lw with three wait cycles in MEMRD, then an add to show the return to FETCH.
    st_log.delete();
    gen_instr(LW, 6'd0, 1'b0, 0, 3);
    gen_instr(RT, 6'b100000, 1'b0, 0, 0);
    run_q();
    for (int i = 0; i < 9; i++) chk($sformatf("lw_seq%0d", i), 8'(st_log[i]), 8'(lw_seq[i]));

    // R-type table, including an unsupported funct.
    gen_instr(RT, 6'b100010, 1'b0, 0, 0);
    gen_instr(RT, 6'b100111, 1'b0, 0, 0);
    gen_instr(RT, 6'b101010, 1'b0, 0, 0);
    gen_instr(RT, 6'b000000, 1'b0, 0, 0);
    gen_instr(RT, 6'b100100, 1'b0, 1, 0);
    gen_instr(RT, 6'b100101, 1'b0, 0, 0);
    // Branch both ways, illegal opcodes, addi, jump, sw, fetch waits.
    gen_instr(BEQ, 6'd0, 1'b1, 0, 0);
    gen_instr(BEQ, 6'd0, 1'b0, 0, 0);
    gen_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    gen_instr(6'b000011, 6'd0, 1'b0, 0, 0);
    gen_instr(ADDI, 6'd5, 1'b0, 0, 0);
    gen_instr(JMP, 6'd0, 1'b0, 2, 0);
    gen_instr(SW, 6'd0, 1'b0, 0, 0);
    // Ready arriving exactly when the count reaches the limit still succeeds.
    gen_instr(LW, 6'd0, 1'b0, 0, TMO);
    gen_instr(SW, 6'd0, 1'b1, TMO, TMO);
    run_q();
    chk("no_timeout_yet", 8'(mem_timeout), 8'd0);

    // sw that never gets ready: 16 write cycles, then a sticky flag.
    st_log.delete();
    gen_instr(SW, 6'd0, 1'b0, 0, 100);
    gen_instr(RT, 6'b100000, 1'b0, 0, 0);
    gen_instr(BEQ, 6'd0, 1'b1, 0, 0);
    run_q();
    cnt = 0;
    foreach (st_log[i]) if (st_log[i] == 5) cnt++;
    chk("to_write_cycles", 8'(cnt), 8'd16);
    chk("to_state_after", 8'(st_log[19]), 8'd0);
    chk("to_sticky", 8'(mem_timeout), 8'd1);

    // Reset in the middle of a memory write.
    gen_fetch(SW, 6'd0, 1'b0, 0);
    q.push_back(mk(1, SW, 6'd0, 1'b0, 1'b1));
    q.push_back(mk(2, SW, 6'd0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) q.push_back(mk(5, SW, 6'd0, 1'b0, 1'b0));
    run_q();
    #1;
    chk("pre_rst_mem_write", 8'(mem_write), 8'd1);
    chk("pre_rst_state", 8'(state), 8'd5);
    reset = 1'b1;
    #1;
    chk("async_rst_mem_write", 8'(mem_write), 8'd0);
    chk("async_rst_state", 8'(state), 8'd0);
    chk("async_rst_timeout", 8'(mem_timeout), 8'd0);
    chk("async_rst_mem_read", 8'(mem_read), 8'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sticky_to = 1'b0;

    // lw with ready tied high takes five cycles.
    st_log.delete();
    gen_instr(LW, 6'd0, 1'b0, 0, 0);
    run_q();
    chk("lw_fast_cycles", 8'(st_log.size()), 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
